// File: rtl/dot_product_engine_if.sv
// dot_product_engine_if: beat stream in, result stream out for dot_product_engine.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif
interface dot_product_engine_if #(
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ACC_WIDTH  = `ACC_WIDTH
);
    logic                                in_valid;
    logic                                in_ready;
    logic [LANES-1:0][DATA_WIDTH-1:0]    in_x;
    logic [LANES-1:0][DATA_WIDTH-1:0]    in_w;
    logic                                out_valid;
    logic                                out_ready;
    logic signed [ACC_WIDTH-1:0]         out_dp;
    logic                                out_overflow;
    modport master (
        output in_valid, in_x, in_w, out_ready,
        input  in_ready, out_valid, out_dp, out_overflow
    );
    modport slave (
        input  in_valid, in_x, in_w, out_ready,
        output in_ready, out_valid, out_dp, out_overflow
    );
endinterface

// File: rtl/dot_product_engine.sv
// dot_product_engine: streamed signed dot product, LANES products per beat.
// Define DOT_PRODUCT_SATURATE_EN to clamp out-of-range results instead of wrapping.
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif
`ifndef ACC_WIDTH
`define ACC_WIDTH 16
`endif
module dot_product_engine #(
    parameter int N          = 16,
    parameter int LANES      = 4,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int ACC_WIDTH  = `ACC_WIDTH
) (
    input  logic clk,
    input  logic rst_n,
    input  logic flush,
    dot_product_engine_if.slave bus
);
    localparam int BEATS = N / LANES;
    localparam int CW    = BEATS > 1 ? $clog2(BEATS) : 1;
    localparam int PW    = 2 * DATA_WIDTH;
    localparam int AW    = PW + $clog2(N) + 1;

    if (LANES < 1 || N % LANES != 0 || BEATS < 1 || ACC_WIDTH > AW) begin : g_bad_cfg
        $error("dot_product_engine: invalid N/LANES/ACC_WIDTH combination");
    end

    typedef enum logic {ACCUM, DONE} state_t;
    state_t state, state_nx;

    logic [CW-1:0]                cnt;
    logic signed [AW-1:0]         acc, beat_sum, total;
    logic signed [PW-1:0]         prod [LANES];
    logic signed [ACC_WIDTH-1:0]  dp_nx;
    logic                         accept, last, ovf;

    assign accept = bus.in_valid && bus.in_ready && !flush;
    assign last   = accept && cnt == CW'(BEATS - 1);

    always_comb begin
        beat_sum = '0;
        for (int k = 0; k < LANES; k++) begin
            prod[k]  = $signed(bus.in_x[k]) * $signed(bus.in_w[k]);
            beat_sum = beat_sum + AW'(prod[k]);
        end
    end

    assign total = acc + beat_sum;
    // In range iff every bit from the ACC_WIDTH sign bit upward agrees.
    assign ovf = !((&total[AW-1:ACC_WIDTH-1]) || !(|total[AW-1:ACC_WIDTH-1]));

`ifdef DOT_PRODUCT_SATURATE_EN
    assign dp_nx = !ovf ? total[ACC_WIDTH-1:0] :
                   total[AW-1] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
`else
    assign dp_nx = total[ACC_WIDTH-1:0];
`endif

    always_comb begin
        state_nx = state;
        if (flush)
            state_nx = ACCUM;
        else if (state == ACCUM && last)
            state_nx = DONE;
        else if (state == DONE && bus.out_ready)
            state_nx = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ACCUM;
            cnt              <= '0;
            acc              <= '0;
            bus.in_ready     <= 1'b0;
            bus.out_valid    <= 1'b0;
            bus.out_dp       <= '0;
            bus.out_overflow <= 1'b0;
        end else begin
            state         <= state_nx;
            bus.in_ready  <= state_nx == ACCUM;
            bus.out_valid <= state_nx == DONE;
            if (flush || last) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                acc <= total;
                cnt <= cnt + 1'b1;
            end
            if (last) begin
                bus.out_dp       <= dp_nx;
                bus.out_overflow <= ovf;
            end
        end
    end
endmodule

// File: doc/dot_product_engine.md
# dot_product_engine

Sequential, handshaked successor to the combinational dot-product unit. It accepts an N-element signed vector pair as a stream of LANES-wide beats and accumulates LANES products per cycle in a guard-bit-wide accumulator. It presents the ACC_WIDTH result through a valid/ready output with an overflow flag. It sits between the perceptron's operand buffers and its activation stage, and trades area for throughput through LANES.

## Interface
- N, 16: vector length; N % LANES == 0 and N/LANES >= 1 (elaboration-time assertion).
- LANES, 4: elements consumed per accepted beat.
- DATA_WIDTH, `DATA_WIDTH: signed operand width.
- ACC_WIDTH, `ACC_WIDTH: signed result width.
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current vector/result.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_x  in  LANES x DATA_WIDTH signed  x elements; lane k carries element beat*LANES+k.
- in_w  in  LANES x DATA_WIDTH signed  w elements, same ordering.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- out_dp  out  ACC_WIDTH signed  dot product.
- out_overflow  out  1  final sum outside ACC_WIDTH signed range.

## Operation
- Internal accumulator width: AW = 2*DATA_WIDTH + $clog2(N) + 1. Every product is a full signed 2*DATA_WIDTH value, sign-extended to AW. The accumulator cannot overflow internally.
- The beat counter runs 0..N/LANES-1 and needs no in_last: the final beat is the one accepted with count == N/LANES-1.
- States:
  - ACCUM: in_ready=1.
    - On an accepted beat, acc += sum of the LANES products and the counter increments.
    - On the final beat, out_dp/out_overflow are loaded from acc plus that beat's products. acc and the counter then clear and the state moves to DONE.
  - DONE: in_ready=0, out_valid=1, and out_dp/out_overflow are held stable.
    - When out_ready is high, out_valid drops and the state returns to ACCUM.
- flush:
  - Highest priority. It clears acc and the counter and forces ACCUM.
  - A beat presented in the same cycle is discarded (not counted).
  - flush in DONE drops out_valid. If out_ready was also high that cycle, the result counts as delivered.
- Result narrowing from AW to ACC_WIDTH is per Configuration.

## Timing
- Reset values (asynchronous, while rst_n=0): state ACCUM, counter 0, acc 0, in_ready 0, out_valid 0, out_dp 0, out_overflow 0.
- in_ready is registered. It rises on the first rising edge after rst_n deasserts.
- Latency: out_valid rises the cycle after the final beat is accepted.
- Throughput: one vector per N/LANES+1 cycles with out_ready held high. There is no input/output overlap.
- Back-pressure: out_dp and out_overflow are held unchanged while out_valid=1 and out_ready=0. in_ready stays 0 for that whole time.
- in_valid gaps (bubbles) between beats are allowed. acc and the counter hold during gaps.
- Reset asserted mid-vector or mid-DONE: all state returns to the reset values immediately, and any partial vector is lost.

## Configuration
- DOT_PRODUCT_SATURATE_EN defined:
  - If the AW sum > 2^(ACC_WIDTH-1)-1, out_dp = that maximum and out_overflow=1.
  - If the sum < -2^(ACC_WIDTH-1), out_dp = that minimum and out_overflow=1.
  - Otherwise out_dp is exact and out_overflow=0.
- Undefined:
  - out_dp = low ACC_WIDTH bits of the sum (two's-complement wrap).
  - out_overflow still reports an out-of-range sum, so the flag is identical in both builds.

## Test plan
Configuration for all scenarios: N=4, LANES=2, DATA_WIDTH=8, ACC_WIDTH=16.
- Basic: x={1,2,3,4}, w={5,6,7,8} in 2 beats, out_ready=1 -> out_dp=70, out_overflow=0, out_valid for 1 cycle, 1 cycle after beat 2.
- Positive overflow: all x=127, w=127 -> SAT build: out_dp=32767, overflow=1; wrap build: out_dp=-1020, overflow=1.
- Negative overflow: all x=-128, w=127 -> SAT build: out_dp=-32768, overflow=1; wrap build: out_dp=512, overflow=1.
- Back-pressure and bubbles: idle cycle between beats, then out_ready=0 for 5 cycles -> out_dp=70 stable, in_ready=0 throughout; accepted on cycle 6, in_ready=1 next cycle.
- flush after beat 1 of {1,2,…}, then a full new vector {1,1,1,1}·{2,2,2,2} -> out_dp=8 (no stale partial); flush with beat in the same cycle -> that beat not counted.
- rst_n pulsed low mid-vector and in DONE -> all outputs 0 immediately, in_ready=1 first edge after release, next vector computes correctly.
